// File: rtl/i2s_pkg.sv
// Constants and types shared by the I2S transmit and capture sides.
package i2s_pkg;

    localparam int SAMPLE_BITS = 24;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BITS  = 64;
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS);
    localparam int SLOT_CNT_W  = $clog2(SLOT_BITS);

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    // Slot bit 0 is the one-BCLK I2S delay; bits past the sample width are padding.
    function automatic logic slot_carries_data(input logic [SLOT_CNT_W-1:0] k);
        return (k != '0) && (int'(k) <= SAMPLE_BITS);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every HALF_DIV system clocks and flags the
// cycle whose edge produces each rising or falling transition.
module i2s_bclk_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam int               CNT_W    = $clog2(HALF_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             half_done;

    assign half_done = (div_cnt == CNT_LAST);
    assign bclk_rise = half_done && !bclk;
    assign bclk_fall = half_done && bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_24.sv
// I2S transmitter for 24-bit stereo samples in 32-bit slots, with a single
// holding register between the valid/ready handshake and the frame shifters.
module i2s_tx_24
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic signed [SAMPLE_BITS-1:0] left_i,
    input  logic signed [SAMPLE_BITS-1:0] right_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    output logic                          bclk_o,
    output logic                          lrclk_o,
    output logic                          sd_o,
    output logic                          frame_start_o,
    output logic                          underrun_o
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    logic                  bclk_rise;
    logic                  bclk_fall;
    logic                  unused_rise;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_next;
    logic [SLOT_CNT_W-1:0] slot_bit;
    logic                  right_slot;
    logic                  frame_load;
    logic                  accept;
    logic                  hold_full;
    stereo_t               hold;
    stereo_t               shift;

    i2s_bclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_bclk_gen (
        .clk       (clk_i),
        .rst       (rst_i),
        .bclk      (bclk_o),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall)
    );

    // Outputs only move on falls; the rise strobe is there for the capture side.
    assign unused_rise = bclk_rise;

    assign bit_next       = bit_cnt + 1'b1;
    assign slot_bit       = bit_next[SLOT_CNT_W-1:0];
    assign right_slot     = bit_next[BIT_CNT_W-1];
    assign frame_load     = bclk_fall && (bit_cnt == BIT_LAST);
    assign accept         = sample_valid_i && !hold_full;
    assign sample_ready_o = !hold_full;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            hold.left  <= left_i;
            hold.right <= right_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt       <= BIT_LAST;
            lrclk_o       <= 1'b1;
            sd_o          <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            hold_full     <= 1'b0;
            shift         <= '0;
        end else begin
            frame_start_o <= frame_load;
            underrun_o    <= frame_load && !hold_full;

            // A load sees the pre-cycle holding state, so a same-cycle accept lands next frame.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (frame_load) begin
                hold_full <= 1'b0;
            end

            if (bclk_fall) begin
                bit_cnt <= bit_next;
                lrclk_o <= right_slot;
                sd_o    <= 1'b0;
                if (frame_load) begin
                    shift <= hold_full ? hold : '0;
                end else if (slot_carries_data(slot_bit)) begin
                    if (right_slot) begin
                        sd_o        <= shift.right[SAMPLE_BITS-1];
                        shift.right <= shift.right <<< 1;
                    end else begin
                        sd_o       <= shift.left[SAMPLE_BITS-1];
                        shift.left <= shift.left <<< 1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_24.sv
// Self-checking bench for i2s_tx_24: handshake scoreboard plus a bit-level
// monitor that decodes each frame on bclk rises.
`timescale 1ns/1ps
module tb_i2s_tx_24;

    localparam int HD        = 2;
    localparam int FRAME_CYC = 128 * HD;
    localparam int NV        = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] left = '0;
    logic [23:0] right = '0;
    logic        valid = 1'b0;
    logic        ready, bclk, lrclk, sd, fs, ur;

    i2s_tx_24 #(.HALF_DIV(HD)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .left_i         (left),
        .right_i        (right),
        .sample_valid_i (valid),
        .sample_ready_o (ready),
        .bclk_o         (bclk),
        .lrclk_o        (lrclk),
        .sd_o           (sd),
        .frame_start_o  (fs),
        .underrun_o     (ur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int unsigned at;
    } sb_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        string name;
        logic  exp;
    } rst_vec_t;

    sb_t         sb[$];
    sb_t         cur;
    vec_t        tab[NV];
    rst_vec_t    rst_tab[6];
    int          checks = 0;
    int          failures = 0;
    int unsigned edges = 0;
    int unsigned rel_edge = 0;
    int unsigned last_load = 0;
    int unsigned hs_edge = 0;

    logic        bits[64];
    logic        lrs[64];
    logic        collecting = 1'b0;
    int          idx = 0;
    logic        first_pending = 1'b1;
    logic        exp_ur;
    logic        prev_bclk, prev_lr, prev_sd, seen_toggle;
    int          since = 0;
    int          timing_err = 0;
    int          frames_done = 0;
    logic [23:0] got_l, got_r;
    logic        zero_ok, lr_ok;

    always @(posedge clk) edges++;
    always @(negedge rst) rel_edge = edges;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic rst_out(input int i);
        case (i)
            0:       return bclk;
            1:       return lrclk;
            2:       return sd;
            3:       return fs;
            4:       return ur;
            default: return ready;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        left  = l;
        right = r;
        valid = 1'b1;
        while (!ready && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", ready, 1);
        if (ready) begin
            hs_edge = edges + 1;
            sb.push_back('{l: l, r: r, at: edges + 1});
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    // Frame monitor: expected frame chosen at each load, bits gathered on rises.
    always @(negedge clk) begin
        if (rst) begin
            collecting    = 1'b0;
            idx           = 0;
            first_pending = 1'b1;
            sb.delete();
            prev_bclk     = 1'b0;
            prev_lr       = 1'b1;
            prev_sd       = 1'b0;
            seen_toggle   = 1'b0;
            since         = 0;
        end else begin
            since++;
            if (bclk !== prev_bclk) begin
                if (seen_toggle && since != HD) timing_err++;
                seen_toggle = 1'b1;
                since       = 0;
            end
            if ((lrclk !== prev_lr || sd !== prev_sd) && !(prev_bclk && !bclk)) timing_err++;
            if (ur && !fs) timing_err++;
            if (fs) begin
                if (first_pending) chk("first_load_delay", edges - rel_edge, 2 * HD);
                else chk("frame_period", edges - last_load, FRAME_CYC);
                if (collecting) chk("frame_incomplete", idx, 64);
                first_pending = 1'b0;
                last_load     = edges;
                if (sb.size() > 0 && sb[0].at < edges) begin
                    cur    = sb.pop_front();
                    exp_ur = 1'b0;
                end else begin
                    cur    = '{l: 24'h0, r: 24'h0, at: 0};
                    exp_ur = 1'b1;
                end
                chk("underrun_flag", ur, exp_ur);
                collecting = 1'b1;
                idx        = 0;
            end
            if (collecting && !prev_bclk && bclk) begin
                bits[idx] = sd;
                lrs[idx]  = lrclk;
                idx++;
                if (idx == 64) begin
                    zero_ok = 1'b1;
                    lr_ok   = 1'b1;
                    for (int i = 0; i < 64; i++) begin
                        if (((i % 32) == 0 || (i % 32) > 24) && bits[i] !== 1'b0) zero_ok = 1'b0;
                        if (lrs[i] !== (i >= 32)) lr_ok = 1'b0;
                    end
                    for (int k = 0; k < 24; k++) begin
                        got_l[23-k] = bits[1+k];
                        got_r[23-k] = bits[33+k];
                    end
                    chk("left_data", got_l, cur.l);
                    chk("right_data", got_r, cur.r);
                    chk("pad_zero", zero_ok, 1);
                    chk("lrclk_slot", lr_ok, 1);
                    collecting = 1'b0;
                    frames_done++;
                end
            end
            prev_bclk = bclk;
            prev_lr   = lrclk;
            prev_sd   = sd;
        end
    end

    initial begin
        int n;
        rst_tab[0] = '{name: "rst_bclk",        exp: 1'b0};
        rst_tab[1] = '{name: "rst_lrclk",       exp: 1'b1};
        rst_tab[2] = '{name: "rst_sd",          exp: 1'b0};
        rst_tab[3] = '{name: "rst_frame_start", exp: 1'b0};
        rst_tab[4] = '{name: "rst_underrun",    exp: 1'b0};
        rst_tab[5] = '{name: "rst_ready",       exp: 1'b1};

        tab[0] = '{l: 24'hA5A5A5, r: 24'h800001, exp_ready: 1'b0};
        tab[1] = '{l: 24'h7FFFFF, r: 24'h000000, exp_ready: 1'b0};
        tab[2] = '{l: 24'h000001, r: 24'hFFFFFF, exp_ready: 1'b0};
        tab[3] = '{l: 24'h123456, r: 24'hFEDCBA, exp_ready: 1'b0};
        tab[4] = '{l: 24'h800000, r: 24'h7FFFFF, exp_ready: 1'b0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) chk(rst_tab[i].name, rst_out(i), rst_tab[i].exp);
        rst = 1'b0;

        // No samples offered: first two frames must be underruns of zeros.
        repeat (2 * HD + FRAME_CYC + 8) @(negedge clk);

        // Back-to-back pairs: each later pair is taken the cycle after a load.
        for (int i = 0; i < NV; i++) begin
            send(tab[i].l, tab[i].r);
            chk("ready_after_handshake", ready, tab[i].exp_ready);
            if (i > 0) chk("accept_after_load", hs_edge, last_load + 1);
        end

        // Valid arriving in the load cycle with an empty holding register.
        n = 0;
        while (sb.size() != 0 && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        chk("drain_before_simul", sb.size(), 0);
        n = 0;
        while (edges != last_load + FRAME_CYC - 1 && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        send(24'h5A5A5A, 24'h0F0F0F);
        @(negedge clk);
        chk("simul_handshake_at_load", hs_edge, last_load);

        // Reset at bit 40 while a second sample is held.
        send(24'h111111, 24'h222222);
        send(24'h333333, 24'h444444);
        n = 0;
        while (!(collecting && idx == 40) && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        chk("reached_bit40", idx, 40);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) chk({"mid_", rst_tab[i].name}, rst_out(i), rst_tab[i].exp);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * HD + FRAME_CYC + 8) @(negedge clk);

        chk("timing_events", timing_err, 0);
        chk("frames_decoded_min", frames_done >= 10, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
